// File: rtl/bank_cmd_scheduler_pkg.sv
// Shared widths, command encodings and sequencer states for the DRAM bank command scheduler.
package bank_cmd_scheduler_pkg;

  localparam int ROW_W  = 16;
  localparam int COL_W  = 10;
  localparam int BG_W   = 2;
  localparam int BA_W   = 2;
  localparam int IDX_W  = BG_W + BA_W;
  localparam int NBANKS = 1 << IDX_W;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_RW,
    ST_REFP,
    ST_REFP_WAIT,
    ST_REF,
    ST_REF_WAIT
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bank_cmd_scheduler_bank_state_table.sv
// Open-row store for 16 banks: a valid bit plus the open row per {bg,bank}.
import bank_cmd_scheduler_pkg::*;

module bank_state_table (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic             clr_en,
  input  logic             clr_all,
  input  logic [IDX_W-1:0] idx,
  input  logic [ROW_W-1:0] row,
  output logic             hit,
  output logic             open,
  output logic             any_open
);

  logic [NBANKS-1:0] valid_q, valid_d;
  logic [ROW_W-1:0]  row_q [NBANKS];
  logic [ROW_W-1:0]  row_d [NBANKS];

  always_comb begin
    valid_d = valid_q;
    row_d   = row_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (clr_en) begin
      valid_d[idx] = 1'b0;
    end else if (set_en) begin
      valid_d[idx] = 1'b1;
      row_d[idx]   = row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Row contents are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    row_q <= row_d;
  end

  assign open     = valid_q[idx];
  assign hit      = valid_q[idx] && (row_q[idx] == row);
  assign any_open = |valid_q;

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Single-request DRAM command sequencer: open-page ACT/RD/WR/PRE with tRCD/tRP/tCCD spacing plus PREA/REF refresh.
import bank_cmd_scheduler_pkg::*;

module bank_cmd_scheduler #(
  parameter int TRCD = 4,
  parameter int TRP  = 4,
  parameter int TCCD = 4,
  parameter int TRFC = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic [BG_W-1:0]  req_bg,
  input  logic [BA_W-1:0]  req_bank,
  output logic             req_ready,
  input  logic             ref_req,
  output logic             ref_ack,
  output logic             cmd_valid,
  output logic [2:0]       cmd_op,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic [BG_W-1:0]  cmd_bg,
  output logic [BA_W-1:0]  cmd_bank
);

  localparam int CNT_W  = $clog2(max3(TRCD, TRP, TRFC)) + 1;
  localparam int TCCD_W = $clog2(TCCD) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TCCD_W-1:0] tccd_q, tccd_d;

  logic              cmd_valid_q, cmd_valid_d;
  cmd_op_e           cmd_op_q, cmd_op_d;
  logic [ROW_W-1:0]  cmd_row_q, cmd_row_d;
  logic [COL_W-1:0]  cmd_col_q, cmd_col_d;
  logic [BG_W-1:0]   cmd_bg_q, cmd_bg_d;
  logic [BA_W-1:0]   cmd_bank_q, cmd_bank_d;
  logic              req_ready_q, req_ready_d;
  logic              ref_ack_q, ref_ack_d;

  logic tbl_hit, tbl_open, tbl_any_open;

  bank_state_table u_table (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .set_en   (state_d == ST_ACT),
    .clr_en   (state_d == ST_PRE),
    .clr_all  (state_d == ST_REFP),
    .idx      ({req_bg, req_bank}),
    .row      (req_row),
    .hit      (tbl_hit),
    .open     (tbl_open),
    .any_open (tbl_any_open)
  );

  // Issuing states last exactly one cycle, so state_d landing on one marks the issue edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    tccd_d  = (tccd_q != '0) ? tccd_q - 1'b1 : '0;
    unique case (state_q)
      ST_IDLE: begin
        if (ref_req)        state_d = tbl_any_open ? ST_REFP : ST_REF;
        else if (req_valid) state_d = tbl_hit ? ST_RW : (tbl_open ? ST_PRE : ST_ACT);
      end
      ST_PRE, ST_PRE_WAIT:   state_d = (cnt_q == '0) ? ST_ACT : ST_PRE_WAIT;
      ST_ACT, ST_ACT_WAIT:   state_d = (cnt_q == '0) ? ST_RW : ST_ACT_WAIT;
      ST_RW: begin
        if (tccd_q == '0) begin
          state_d = ST_IDLE;
          tccd_d  = TCCD_W'(TCCD - 1);
        end
      end
      ST_REFP, ST_REFP_WAIT: state_d = (cnt_q == '0) ? ST_REF : ST_REFP_WAIT;
      ST_REF, ST_REF_WAIT:   state_d = (cnt_q == '0) ? ST_IDLE : ST_REF_WAIT;
      default:               state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_PRE, ST_REFP: cnt_d = CNT_W'(TRP - 1);
      ST_ACT:          cnt_d = CNT_W'(TRCD - 1);
      ST_REF:          cnt_d = CNT_W'(TRFC - 1);
      default: ;
    endcase
  end

  // Outputs are registered from the state being entered, so the command lands in that state's cycle.
  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_op_d    = CMD_NOP;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    cmd_bg_d    = '0;
    cmd_bank_d  = '0;
    req_ready_d = 1'b0;
    ref_ack_d   = 1'b0;
    unique case (state_d)
      ST_PRE: begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = CMD_PRE;
        cmd_bg_d    = req_bg;
        cmd_bank_d  = req_bank;
      end
      ST_ACT: begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = CMD_ACT;
        cmd_row_d   = req_row;
        cmd_bg_d    = req_bg;
        cmd_bank_d  = req_bank;
      end
      ST_RW: begin
        if (tccd_d == '0) begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = req_we ? CMD_WR : CMD_RD;
          cmd_col_d   = req_col;
          cmd_bg_d    = req_bg;
          cmd_bank_d  = req_bank;
          req_ready_d = 1'b1;
        end
      end
      ST_REFP: begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = CMD_PREA;
      end
      ST_REF: begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = CMD_REF;
        ref_ack_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tccd_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= CMD_NOP;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_bg_q    <= '0;
      cmd_bank_q  <= '0;
      req_ready_q <= 1'b0;
      ref_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tccd_q      <= tccd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_bank_q  <= cmd_bank_d;
      req_ready_q <= req_ready_d;
      ref_ack_q   <= ref_ack_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign cmd_bg    = cmd_bg_q;
  assign cmd_bank  = cmd_bank_q;
  assign req_ready = req_ready_q;
  assign ref_ack   = ref_ack_q;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Directed bench for bank_cmd_scheduler: command ordering, spacing, refresh and reset recovery.
module tb_bank_cmd_scheduler;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_PRE  = 3'd4;
  localparam logic [2:0] OP_PREA = 3'd5;
  localparam logic [2:0] OP_REF  = 3'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_ready;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic [1:0]  req_bg, req_bank;
  logic        ref_req, ref_ack;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [1:0]  cmd_bg, cmd_bank;

  int checks = 0;
  int errors = 0;

  logic [2:0]  op_s;
  logic [15:0] row_s;
  logic [9:0]  col_s;
  logic [1:0]  bg_s, bank_s;
  logic        rdy_s, ack_s;
  int          n;

  bank_cmd_scheduler #(.TRCD(4), .TRP(4), .TCCD(4), .TRFC(32)) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_bg    (req_bg),
    .req_bank  (req_bank),
    .req_ready (req_ready),
    .ref_req   (ref_req),
    .ref_ack   (ref_ack),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_bg    (cmd_bg),
    .cmd_bank  (cmd_bank)
  );

  always #5 clk = ~clk;

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the next command strobe; cyc = edges advanced, or -1 if none within limit.
  task automatic next_cmd(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      step(1);
      if (cmd_valid === 1'b1) begin
        op_s = cmd_op; row_s = cmd_row; col_s = cmd_col;
        bg_s = cmd_bg; bank_s = cmd_bank; rdy_s = req_ready; ack_s = ref_ack;
        cyc = i;
        break;
      end
    end
  endtask

  task automatic present(input logic we, input logic [15:0] row, input logic [9:0] col,
                         input logic [1:0] bg, input logic [1:0] bank);
    req_valid = 1'b1; req_we = we; req_row = row; req_col = col; req_bg = bg; req_bank = bank;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    checks++; if (cmd_valid !== 1'b0 || cmd_op !== OP_NOP) begin errors++;
      $display("FAIL reset_cmd: valid=%b op=%0d, expected 0/0", cmd_valid, cmd_op); end
    checks++; if (req_ready !== 1'b0 || ref_ack !== 1'b0) begin errors++;
      $display("FAIL reset_hs: ready=%b ack=%b, expected 0/0", req_ready, ref_ack); end
    checks++; if ({cmd_row, cmd_col, cmd_bg, cmd_bank} !== 30'd0) begin errors++;
      $display("FAIL reset_fields: row=%h col=%h bg=%0d bank=%0d, expected all 0", cmd_row, cmd_col, cmd_bg, cmd_bank); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_refresh_idle;
    ref_req = 1'b1;
    next_cmd(10, n);
    checks++; if (n !== 1 || op_s !== OP_REF || ack_s !== 1'b1) begin errors++;
      $display("FAIL ref_idle: cyc=%0d op=%0d ack=%b, expected 1/REF(6)/1", n, op_s, ack_s); end
    ref_req = 1'b0;
    step(40);
    checks++; if (cmd_valid !== 1'b0) begin errors++;
      $display("FAIL ref_idle_quiet: cmd_valid=%b, expected 0", cmd_valid); end
  endtask

  task automatic test_closed_read;
    present(1'b0, 16'h0123, 10'h010, 2'd1, 2'd2);
    next_cmd(10, n);
    checks++; if (n !== 1 || op_s !== OP_ACT || row_s !== 16'h0123 || bg_s !== 2'd1 || bank_s !== 2'd2) begin errors++;
      $display("FAIL closed_act: cyc=%0d op=%0d row=%h bg=%0d bank=%0d, expected 1/ACT/0123/1/2", n, op_s, row_s, bg_s, bank_s); end
    next_cmd(20, n);
    checks++; if (n !== 4 || op_s !== OP_RD || col_s !== 10'h010 || rdy_s !== 1'b1 || row_s !== 16'h0) begin errors++;
      $display("FAIL closed_rd: cyc=%0d op=%0d col=%h ready=%b row=%h, expected 4/RD/010/1/0", n, op_s, col_s, rdy_s, row_s); end
    req_valid = 1'b0;
    step(1);
    checks++; if (req_ready !== 1'b0) begin errors++;
      $display("FAIL closed_ready_pulse: ready=%b, expected 0", req_ready); end
    step(7);
  endtask

  task automatic test_back_to_back;
    present(1'b0, 16'h0123, 10'h020, 2'd1, 2'd2);
    next_cmd(10, n);
    checks++; if (n !== 1 || op_s !== OP_RD || col_s !== 10'h020 || rdy_s !== 1'b1) begin errors++;
      $display("FAIL b2b_first: cyc=%0d op=%0d col=%h ready=%b, expected 1/RD/020/1", n, op_s, col_s, rdy_s); end
    req_col = 10'h030;
    next_cmd(20, n);
    checks++; if (n !== 4 || op_s !== OP_RD || col_s !== 10'h030 || rdy_s !== 1'b1) begin errors++;
      $display("FAIL b2b_second: cyc=%0d op=%0d col=%h ready=%b, expected 4/RD/030/1", n, op_s, col_s, rdy_s); end
    req_valid = 1'b0;
    step(8);
  endtask

  task automatic test_miss_write;
    present(1'b1, 16'h0456, 10'h040, 2'd1, 2'd2);
    next_cmd(10, n);
    checks++; if (n !== 1 || op_s !== OP_PRE || bg_s !== 2'd1 || bank_s !== 2'd2 || row_s !== 16'h0) begin errors++;
      $display("FAIL miss_pre: cyc=%0d op=%0d bg=%0d bank=%0d row=%h, expected 1/PRE/1/2/0", n, op_s, bg_s, bank_s, row_s); end
    next_cmd(20, n);
    checks++; if (n !== 4 || op_s !== OP_ACT || row_s !== 16'h0456) begin errors++;
      $display("FAIL miss_act: cyc=%0d op=%0d row=%h, expected 4/ACT/0456", n, op_s, row_s); end
    next_cmd(20, n);
    checks++; if (n !== 4 || op_s !== OP_WR || col_s !== 10'h040 || rdy_s !== 1'b1) begin errors++;
      $display("FAIL miss_wr: cyc=%0d op=%0d col=%h ready=%b, expected 4/WR/040/1", n, op_s, col_s, rdy_s); end
    req_valid = 1'b0;
    step(8);
  endtask

  task automatic test_refresh_open;
    int gap;
    ref_req = 1'b1;
    present(1'b0, 16'h0456, 10'h005, 2'd1, 2'd2);
    next_cmd(10, n);
    checks++; if (n !== 1 || op_s !== OP_PREA || bg_s !== 2'd0 || bank_s !== 2'd0) begin errors++;
      $display("FAIL refo_prea: cyc=%0d op=%0d bg=%0d bank=%0d, expected 1/PREA/0/0", n, op_s, bg_s, bank_s); end
    next_cmd(20, n);
    checks++; if (n !== 4 || op_s !== OP_REF || ack_s !== 1'b1 || rdy_s !== 1'b0) begin errors++;
      $display("FAIL refo_ref: cyc=%0d op=%0d ack=%b ready=%b, expected 4/REF/1/0", n, op_s, ack_s, rdy_s); end
    ref_req = 1'b0;
    next_cmd(60, gap);
    checks++; if (gap < 32 || op_s !== OP_ACT || row_s !== 16'h0456) begin errors++;
      $display("FAIL refo_after: gap=%0d op=%0d row=%h, expected >=32/ACT/0456", gap, op_s, row_s); end
    next_cmd(20, n);
    checks++; if (n !== 4 || op_s !== OP_RD || rdy_s !== 1'b1 || ack_s !== 1'b0) begin errors++;
      $display("FAIL refo_rd: cyc=%0d op=%0d ready=%b ack=%b, expected 4/RD/1/0", n, op_s, rdy_s, ack_s); end
    req_valid = 1'b0;
    step(8);
  endtask

  task automatic test_reset_midflight;
    present(1'b0, 16'h0AAA, 10'h077, 2'd2, 2'd3);
    next_cmd(10, n);
    checks++; if (n !== 1 || op_s !== OP_ACT || row_s !== 16'h0AAA) begin errors++;
      $display("FAIL rstm_act: cyc=%0d op=%0d row=%h, expected 1/ACT/0AAA", n, op_s, row_s); end
    step(1);
    rst = 1'b1;
    step(1);
    checks++; if (cmd_valid !== 1'b0 || cmd_op !== OP_NOP || req_ready !== 1'b0 || ref_ack !== 1'b0 || cmd_row !== 16'h0) begin errors++;
      $display("FAIL rstm_outputs: valid=%b op=%0d ready=%b ack=%b row=%h, expected all 0", cmd_valid, cmd_op, req_ready, ref_ack, cmd_row); end
    rst = 1'b0;
    next_cmd(10, n);
    checks++; if (n !== 1 || op_s !== OP_ACT || row_s !== 16'h0AAA || rdy_s !== 1'b0) begin errors++;
      $display("FAIL rstm_reissue: cyc=%0d op=%0d row=%h ready=%b, expected 1/ACT/0AAA/0", n, op_s, row_s, rdy_s); end
    next_cmd(20, n);
    checks++; if (n !== 4 || op_s !== OP_RD || col_s !== 10'h077 || rdy_s !== 1'b1) begin errors++;
      $display("FAIL rstm_rd: cyc=%0d op=%0d col=%h ready=%b, expected 4/RD/077/1", n, op_s, col_s, rdy_s); end
    req_valid = 1'b0;
    step(4);
  endtask

  initial begin
    rst = 1'b1; ref_req = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_row = '0; req_col = '0; req_bg = '0; req_bank = '0;
    test_reset();
    test_refresh_idle();
    test_closed_read();
    test_back_to_back();
    test_miss_write();
    test_refresh_open();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
